// File: rtl/p8_fp32_dec_pipe.sv
// Two-stage pipelined posit<8,0> -> IEEE-754 binary32 decoder with valid/ready on both sides.
// Optional completed-transfer counter (xfer_cnt) enabled by defining P8_FP32_DEC_CNT_EN.
module p8_fp32_dec_pipe #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NAR_FP32 = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  p8_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp32_out,
  output logic        out_nar
`ifdef P8_FP32_DEC_CNT_EN
  , output logic [CNT_W-1:0] xfer_cnt
`endif
);

  localparam int unsigned AW = 7;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_sign_q, s1_sign_d;
  logic [AW-1:0] s1_a_q, s1_a_d;
  logic          s1_zero_q, s1_zero_d;
  logic          s1_nar_q, s1_nar_d;
  logic          s2_valid_q, s2_valid_d;
  logic [31:0]   fp32_q, fp32_d;
  logic          nar2_q, nar2_d;

  logic          s2_free;
  logic          s1_load;
  logic          s2_load;
  logic [7:0]    p8_neg;
  logic          run;
  logic [3:0]    m;
  logic [AW-1:0] rem;
  logic [7:0]    exp_c;
  logic [31:0]   fp32_c;

  assign s2_free   = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_free;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid_q && s2_free;
  assign out_valid = s2_valid_q;
  assign fp32_out  = fp32_q;
  assign out_nar   = nar2_q;

  // Regime decode: measure the run from bit 6, drop run and terminator, left-align the rest.
  always_comb begin
    run = 1'b1;
    m   = 4'd0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (run && (s1_a_q[i] == s1_a_q[AW-1])) begin
        m = m + 4'd1;
      end else begin
        run = 1'b0;
      end
    end
    rem    = AW'(s1_a_q << (m + 4'd1));
    exp_c  = s1_a_q[AW-1] ? 8'(8'd126 + 8'(m)) : 8'(8'd127 - 8'(m));
    fp32_c = {s1_sign_q, exp_c, rem, 16'd0};
    if (s1_zero_q) begin
      fp32_c = 32'h0000_0000;
    end else if (s1_nar_q) begin
      fp32_c = NAR_FP32;
    end
  end

  // Next-state for both stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_a_d     = s1_a_q;
    s1_zero_d  = s1_zero_q;
    s1_nar_d   = s1_nar_q;
    s2_valid_d = s2_valid_q;
    fp32_d     = fp32_q;
    nar2_d     = nar2_q;
    p8_neg     = 8'(~p8_in + 8'd1);

    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (s1_load) begin
      s1_sign_d = p8_in[7];
      s1_a_d    = p8_in[7] ? p8_neg[AW-1:0] : p8_in[AW-1:0];
      s1_zero_d = (p8_in == 8'h00);
      s1_nar_d  = (p8_in == 8'h80);
    end
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      fp32_d = fp32_c;
      nar2_d = s1_nar_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      fp32_q     <= 32'h0000_0000;
      nar2_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_a_q     <= s1_a_d;
      s1_zero_q  <= s1_zero_d;
      s1_nar_q   <= s1_nar_d;
      s2_valid_q <= s2_valid_d;
      fp32_q     <= fp32_d;
      nar2_q     <= nar2_d;
    end
  end

`ifdef P8_FP32_DEC_CNT_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  // Counts completed output handshakes; wraps naturally.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (s2_valid_q && out_ready) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_p8_fp32_dec_pipe.sv
// Scoreboard bench for p8_fp32_dec_pipe: stimulus pushes expected {nar,fp32}, a negedge monitor pops.
// Define P8_FP32_DEC_CNT_EN to also check xfer_cnt (CNT_W=4).
module tb_p8_fp32_dec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  p8_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp32_out;
  logic        out_nar;
`ifdef P8_FP32_DEC_CNT_EN
  logic [3:0]  xfer_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_pop = 0;
  int xfers = 0;
  int pop_cyc [256];
  logic [32:0] sb [$];

  logic [7:0]  vp [14];
  logic [32:0] ve [14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  p8_fp32_dec_pipe #(.CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .p8_in    (p8_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fp32_out (fp32_out),
    .out_nar  (out_nar)
`ifdef P8_FP32_DEC_CNT_EN
    , .xfer_cnt (xfer_cnt)
`endif
  );

  // Monitor: a handshake seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h nar=%0b expected none", fp32_out, out_nar);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({out_nar, fp32_out} !== e) begin
          bad++;
          $display("FAIL data got nar=%0b fp32=%h expected nar=%0b fp32=%h",
                   out_nar, fp32_out, e[32], e[31:0]);
        end
      end
      if (n_pop < 256) pop_cyc[n_pop] = cyc;
      n_pop++;
      xfers++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] p, input logic [32:0] e);
    bit done = 1'b0;
    in_valid = 1'b1;
    p8_in    = p;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout p8=%h", p);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n0;
    int acc;
    logic [31:0] held;

    // Hand-decoded table: {nar, fp32}
    vp[0]  = 8'h40; ve[0]  = {1'b0, 32'h3F80_0000};
    vp[1]  = 8'h60; ve[1]  = {1'b0, 32'h4000_0000};
    vp[2]  = 8'h50; ve[2]  = {1'b0, 32'h3FC0_0000};
    vp[3]  = 8'hC0; ve[3]  = {1'b0, 32'hBF80_0000};
    vp[4]  = 8'h7F; ve[4]  = {1'b0, 32'h4280_0000};
    vp[5]  = 8'h01; ve[5]  = {1'b0, 32'h3C80_0000};
    vp[6]  = 8'h00; ve[6]  = {1'b0, 32'h0000_0000};
    vp[7]  = 8'h80; ve[7]  = {1'b1, 32'h7FC0_0000};
    vp[8]  = 8'h20; ve[8]  = {1'b0, 32'h3F00_0000};
    vp[9]  = 8'h48; ve[9]  = {1'b0, 32'h3FA0_0000};
    vp[10] = 8'h81; ve[10] = {1'b0, 32'hC280_0000};
    vp[11] = 8'hFF; ve[11] = {1'b0, 32'hBC80_0000};
    vp[12] = 8'h70; ve[12] = {1'b0, 32'h4080_0000};
    vp[13] = 8'h6C; ve[13] = {1'b0, 32'h4060_0000};

    rst = 1'b1; in_valid = 1'b0; p8_in = 8'h00; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fp32", 64'(fp32_out), 64'd0);
    check("rst_nar", 64'(out_nar), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef P8_FP32_DEC_CNT_EN
    check("rst_cnt", 64'(xfer_cnt), 64'd0);
`endif

    // Single word: visible one edge after landing in stage 1.
    send(vp[0], ve[0]);
    @(negedge clk);
    check("lat_s1_only", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    drain();

    // Back-to-back stream; outputs must come on consecutive cycles.
    n0 = n_pop;
    for (int i = 1; i <= 5; i++) send(vp[i], ve[i]);
    drain();
    check("stream_consecutive", 64'(pop_cyc[n0+4] - pop_cyc[n0]), 64'd4);

    send(vp[6], ve[6]);
    send(vp[7], ve[7]);
    for (int i = 8; i < 14; i++) send(vp[i], ve[i]);
    drain();

    // Stall: hold out_ready low for 5 cycles with input offered every cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    held = 32'h0;
    for (int c = 0; c < 5; c++) begin
      p8_in = vp[8 + acc];
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(ve[8 + acc]);
        acc++;
      end
      if (c == 2) held = fp32_out;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_accepts", 64'(acc), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_stable", 64'(fp32_out), 64'(held));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with both stages full: valids drop asynchronously, nothing on release.
    out_ready = 1'b0;
    send(vp[1], ve[1]);
    send(vp[2], ve[2]);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_fp32", 64'(fp32_out), 64'd0);
    sb.delete();
    xfers = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_stale", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);

    // Random backpressure over the full table, then more traffic for counter wrap.
    fork
      begin
        for (int i = 0; i < 14; i++) send(vp[i], ve[i]);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    for (int i = 0; i < 5; i++) send(vp[i], ve[i]);
    drain();
    repeat (2) @(posedge clk);
    #1;
`ifdef P8_FP32_DEC_CNT_EN
    check("cnt_total_xfers", 64'(xfers), 64'd19);
    check("cnt_wrap", 64'(xfer_cnt), 64'(4'(xfers)));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
